xdma_usr_irq_ctrl: RTL
======================

Name: xdma_usr_irq_ctrl

Overview:
- AXI-Lite register slave on the XDMA m_axil port; replaces the GPIO LED block at the same point in the design.
- Provides an 8-bit LED output register.
- Runs a per-channel user-interrupt engine that drives XDMA usr_irq_req[WIRQ-1:0] and completes the usr_irq_ack handshake.
- Interrupt sources: software triggers and fabric event inputs, with mask, pending and acknowledge-count registers readable by the host driver.

Parameters:
- WIRQ, 2, number of user interrupt channels (1..16).
- ADDR_W, 32, AXI-Lite address width; only addr[4:2] is decoded.
- ID_VALUE, 32'h1ED0_0001, constant returned by the ID register.

Ports:
- axi_aclk  in  1  single clock, XDMA user clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- s_axil_awaddr  in  ADDR_W  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid/awready  in/out  1  write-address handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid/wready  in/out  1  write-data handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid/bready  out/in  1  write-response handshake.
- s_axil_araddr  in  ADDR_W  read address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid/arready  in/out  1  read-address handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid/rready  out/in  1  read-data handshake.
- irq_evt  in  WIRQ  fabric event levels, synchronous to axi_aclk; rising edge raises pending.
- usr_irq_req  out  WIRQ  to XDMA.
- usr_irq_ack  in  WIRQ  single-cycle ack pulses from XDMA.
- led  out  8  LED drive.

Behaviour:
- Reset (async assert, sync release): all ready/valid low, bresp/rresp=0, rdata=0, led=0, usr_irq_req=0; mask, pending and ack count all 0; every FSM in IDLE; edge-detect history cleared to 0.

Register map (byte offset, 32-bit, wstrb honoured per byte):
- 0x00 LED: RW [7:0].
- 0x04 MASK: RW [WIRQ-1:0].
- 0x08 PEND: read = pending bits; write 1 clears that bit.
- 0x0C TRIG: write-only; writing 1 sets that pending bit; reads 0.
- 0x10 ACKCNT: RO [15:0], count of received acks across all channels; wraps 0xFFFF->0.
- 0x14 ID: RO, returns ID_VALUE.
- Unmapped offsets (0x18/0x1C): reads return 0, writes are ignored, response OKAY. bresp/rresp are always 2'b00.

Write channel:
- AW and W are accepted independently; each ready drops once its beat is captured.
- The register update and bvalid assertion occur the cycle after both beats are held.
- bvalid is held until bready. No new AW/W is accepted while bvalid=1, so at most 1 write is outstanding.

Read channel:
- arready=1 when rvalid=0.
- rvalid asserts the cycle after the AR handshake, with rdata registered; it is held until rready.
- Reads and writes proceed concurrently. A same-cycle read of PEND returns the pre-write value.

Pending set/clear priority (per bit, per cycle):
- Set sources: TRIG write, or irq_evt rising edge.
- Clear sources: W1C, or ack completion.
- Set wins over any clear, so a new event is never lost.

Per-channel FSM:
- IDLE -> REQ when pend&mask.
- REQ: usr_irq_req=1. On usr_irq_ack: clear pending (unless set same cycle), ACKCNT+1, go to GAP.
- GAP: req=0 for exactly 1 cycle, then IDLE.
- Mask cleared while in REQ: req stays asserted until ack. The protocol forbids dropping req before ack.
- Ack seen in IDLE/GAP: ignored; ACKCNT is not incremented.
- Multiple channels acked in one cycle: ACKCNT increments by popcount.
- Worst-case latency TRIG write -> req: 2 cycles after the W/AW capture.

Decomposition:
- Package xdma_usr_irq_pkg holds:
  - register offset localparams (REG_LED..REG_ID);
  - FSM state enum {IDLE, REQ, GAP};
  - RESP_OKAY constant.
- Sub-module usr_irq_chan: one channel's FSM, edge detect and pending bit; instantiated WIRQ times by generate. The top holds the AXI-Lite slave and the register file.

Test Plan:
- Reset then read 0x14 -> rdata=32'h1ED0_0001, rresp=0; read 0x00 -> 0; led=0.
- Write 0x00=0xA5 with wstrb=4'b0001, AW arriving 3 cycles before W -> single bvalid; led=8'hA5. Then write 0x00=0xFFFFFF00 with wstrb=4'b0001 -> led=8'h00.
- MASK=0x3, TRIG=0x1 -> usr_irq_req=2'b01 within 2 cycles and held. Pulse ack[0] after 10 cycles -> req falls next cycle, PEND=0, ACKCNT=1.
- MASK=0, irq_evt[1] rises -> PEND=0x2, req stays 0. MASK=0x2 -> req[1] asserts. W1C PEND=0x2 while in REQ -> req held until ack.
- Ack[0] coincident with a second TRIG[0] -> PEND[0] stays 1; after the GAP cycle req[0] reasserts; ACKCNT incremented once.
- Deassert axi_aresetn mid-REQ with bvalid pending -> req, bvalid and led go to 0 immediately (asynchronously); after release no spurious req.

Source files
------------

// File: rtl/xdma_usr_irq_pkg.sv
// Shared definitions for the XDMA user-interrupt / LED register block.
package xdma_usr_irq_pkg;

  // Register index = byte offset [4:2]
  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_PEND   = 3'd2;
  localparam logic [2:0] REG_TRIG   = 3'd3;
  localparam logic [2:0] REG_ACKCNT = 3'd4;
  localparam logic [2:0] REG_ID     = 3'd5;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_e;

endpackage

// File: rtl/usr_irq_chan.sv
// One user-interrupt channel: event edge detect, pending bit and the
// req/ack handshake FSM towards XDMA.
module usr_irq_chan
  import xdma_usr_irq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_evt,
  input  logic i_trig,
  input  logic i_w1c,
  input  logic i_mask,
  input  logic i_ack,
  output logic o_req,
  output logic o_pend,
  output logic o_ack_done
);

  irq_state_e r_state, w_state_nxt;
  logic       r_evt_d;
  logic       r_pend;
  logic       w_set;
  logic       w_clr;

  // Acks outside REQ are stray and must not count or clear anything
  assign o_ack_done = (r_state == REQ) & i_ack;
  assign w_set      = i_trig | (i_evt & ~r_evt_d);
  assign w_clr      = i_w1c | o_ack_done;
  assign o_req      = (r_state == REQ);
  assign o_pend     = r_pend;

  // Event history and pending bit; a set always beats a clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_evt_d <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_evt_d <= i_evt;
      r_pend  <= w_set | (r_pend & ~w_clr);
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: req is held until ack regardless of mask, then one idle gap
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_pend && i_mask) w_state_nxt = REQ;
      REQ:     if (i_ack)            w_state_nxt = GAP;
      GAP:                           w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/xdma_usr_irq_ctrl.sv
// AXI-Lite register slave on XDMA m_axil: LED register plus a per-channel
// user-interrupt engine driving usr_irq_req / usr_irq_ack.
module xdma_usr_irq_ctrl
  import xdma_usr_irq_pkg::*;
#(
  parameter int          WIRQ     = 2,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] ID_VALUE = 32'h1ED0_0001
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic [2:0]        s_axil_awprot,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic [2:0]        s_axil_arprot,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  input  logic [WIRQ-1:0]   irq_evt,
  output logic [WIRQ-1:0]   usr_irq_req,
  input  logic [WIRQ-1:0]   usr_irq_ack,
  output logic [7:0]        led
);

  logic            r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic            r_aw_held, r_w_held;
  logic [2:0]      r_awaddr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [31:0]     r_rdata;
  logic [7:0]      r_led;
  logic [WIRQ-1:0] r_mask;
  logic [15:0]     r_ackcnt;

  logic            w_aw_hs, w_w_hs, w_ar_hs, w_wr_do;
  logic            w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;
  logic            w_wr_led, w_wr_mask, w_wr_pend, w_wr_trig;
  logic [WIRQ-1:0] w_trig, w_w1c, w_pend, w_req, w_ack_done;
  logic [15:0]     w_ack_inc;
  logic [31:0]     w_rd_data;
  logic            w_unused;

  assign w_unused = &{1'b0, s_axil_awprot, s_axil_arprot, s_axil_awaddr,
                      s_axil_araddr, r_wdata, r_wstrb};

  assign w_aw_hs = s_axil_awvalid & r_awready;
  assign w_w_hs  = s_axil_wvalid  & r_wready;
  assign w_ar_hs = s_axil_arvalid & r_arready;
  assign w_wr_do = r_aw_held & r_w_held & ~r_bvalid;

  assign w_aw_held_nxt = w_wr_do ? 1'b0 : (r_aw_held | w_aw_hs);
  assign w_w_held_nxt  = w_wr_do ? 1'b0 : (r_w_held  | w_w_hs);
  assign w_bvalid_nxt  = w_wr_do | (r_bvalid & ~s_axil_bready);
  assign w_rvalid_nxt  = w_ar_hs | (r_rvalid & ~s_axil_rready);

  assign w_wr_led  = w_wr_do & (r_awaddr == REG_LED);
  assign w_wr_mask = w_wr_do & (r_awaddr == REG_MASK);
  assign w_wr_pend = w_wr_do & (r_awaddr == REG_PEND);
  assign w_wr_trig = w_wr_do & (r_awaddr == REG_TRIG);

  // Write channel: independent AW/W capture, one write outstanding at a time
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_awready <= ~w_aw_held_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_held_nxt  & ~w_bvalid_nxt;
      if (w_aw_hs) r_awaddr <= s_axil_awaddr[4:2];
      if (w_w_hs) begin
        r_wdata <= s_axil_wdata;
        r_wstrb <= s_axil_wstrb;
      end
    end
  end

  // LED and MASK registers, byte strobes honoured
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_led  <= '0;
      r_mask <= '0;
    end else begin
      if (w_wr_led && r_wstrb[0]) r_led <= r_wdata[7:0];
      for (int i = 0; i < WIRQ; i++)
        if (w_wr_mask && r_wstrb[i/8]) r_mask[i] <= r_wdata[i];
    end
  end

  // Ack counter advances by the number of channels completing this cycle
  always_comb begin
    w_ack_inc = '0;
    for (int i = 0; i < WIRQ; i++) w_ack_inc = w_ack_inc + {15'd0, w_ack_done[i]};
  end

  // ACKCNT, free-running wrap
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_ackcnt <= '0;
    else              r_ackcnt <= r_ackcnt + w_ack_inc;
  end

  // Read mux on the live address; sampled at AR handshake so PEND is pre-write
  always_comb begin
    w_rd_data = '0;
    case (s_axil_araddr[4:2])
      REG_LED:    w_rd_data[7:0]      = r_led;
      REG_MASK:   w_rd_data[WIRQ-1:0] = r_mask;
      REG_PEND:   w_rd_data[WIRQ-1:0] = w_pend;
      REG_ACKCNT: w_rd_data[15:0]     = r_ackcnt;
      REG_ID:     w_rd_data           = ID_VALUE;
      default:    w_rd_data           = '0;
    endcase
  end

  // Read channel: registered data, arready whenever no response is pending
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_ar_hs) r_rdata <= w_rd_data;
    end
  end

  for (genvar g = 0; g < WIRQ; g++) begin : g_chan
    assign w_trig[g] = w_wr_trig & r_wstrb[g/8] & r_wdata[g];
    assign w_w1c[g]  = w_wr_pend & r_wstrb[g/8] & r_wdata[g];

    usr_irq_chan u_chan (
      .i_clk      (axi_aclk),
      .i_rst_n    (axi_aresetn),
      .i_evt      (irq_evt[g]),
      .i_trig     (w_trig[g]),
      .i_w1c      (w_w1c[g]),
      .i_mask     (r_mask[g]),
      .i_ack      (usr_irq_ack[g]),
      .o_req      (w_req[g]),
      .o_pend     (w_pend[g]),
      .o_ack_done (w_ack_done[g])
    );
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = RESP_OKAY;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = RESP_OKAY;
  assign usr_irq_req    = w_req;
  assign led            = r_led;

endmodule
